// File: rtl/seg7_scan_driver_if.sv
// Display bundle between the stopwatch digit source (master) and the
// seven-segment scan driver (slave).
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] i_bcd;
  logic [NUM_DIGITS-1:0]   i_dp;
  logic [NUM_DIGITS-1:0]   i_digit_en;
  logic                    i_blank;
  logic [NUM_DIGITS-1:0]   o_digits;
  logic [7:0]              o_segments;

  modport master (
    output i_bcd, i_dp, i_digit_en, i_blank,
    input  o_digits, o_segments
  );

  modport slave (
    input  i_bcd, i_dp, i_digit_en, i_blank,
    output o_digits, o_segments
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver: one digit per slot,
// frame-coherent digit latch, anti-ghosting blank at the start of each slot.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100_000,
  parameter int BLANK_CYC  = 1_000
) (
  input  logic               i_sys_clk,
  input  logic               i_reset,
  seg7_scan_driver_if.slave  io_disp
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Active-low {g,f,e,d,c,b,a}; non-BCD nibbles show a dash (segment g only).
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h3F;
    endcase
  endfunction

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_bcd;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_en;
  logic [NUM_DIGITS-1:0]   r_digits;
  logic [7:0]              r_segments;

  logic [3:0]              w_nib;
  logic                    w_dark;
  logic [NUM_DIGITS-1:0]   w_digits;
  logic [7:0]              w_segments;

  // Next output pattern from the current slot position and latched frame.
  always_comb begin
    w_nib      = r_bcd[{r_idx, 2'b00} +: 4];
    w_dark     = io_disp.i_blank | (r_cnt < BLANK_LIM) | ~r_en[r_idx];
    w_digits   = {NUM_DIGITS{1'b1}};
    w_segments = 8'hFF;
    if (w_dark) begin
      w_digits   = {NUM_DIGITS{1'b1}};
      w_segments = 8'hFF;
    end else begin
      w_digits   = ~(NUM_DIGITS'(1) << r_idx);
      w_segments = {~r_dp[r_idx], seg7(w_nib)};
    end
  end

  // Slot prescaler, digit index, frame latch and registered outputs.
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_bcd      <= '0;
      r_dp       <= '0;
      r_en       <= '0;
      r_digits   <= {NUM_DIGITS{1'b1}};
      r_segments <= 8'hFF;
    end else begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_idx <= r_idx;
      end
      // Frame start: the blank interval hides this latch from the outputs.
      if ((r_cnt == '0) && (r_idx == '0)) begin
        r_bcd <= io_disp.i_bcd;
        r_dp  <= io_disp.i_dp;
        r_en  <= io_disp.i_digit_en;
      end else begin
        r_bcd <= r_bcd;
        r_dp  <= r_dp;
        r_en  <= r_en;
      end
      r_digits   <= w_digits;
      r_segments <= w_segments;
    end
  end

  assign io_disp.o_digits   = r_digits;
  assign io_disp.o_segments = r_segments;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with SCAN_DIV=4, BLANK_CYC=1.
module tb_seg7_scan_driver;

  localparam int SD    = 4;
  localparam int BC    = 1;
  localparam int FRAME = 8 * SD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seg7_scan_driver_if dif ();

  seg7_scan_driver #(
    .NUM_DIGITS (8),
    .SCAN_DIV   (SD),
    .BLANK_CYC  (BC)
  ) dut (
    .i_sys_clk (clk),
    .i_reset   (rst),
    .io_disp   (dif)
  );

  always #5 clk = ~clk;

  logic [7:0] seg_tab [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};

  // Reference: position p counts cycles since reset release.
  function automatic logic [15:0] model_out(input int p, input logic blank,
                                            input logic [31:0] b, input logic [7:0] dp,
                                            input logic [7:0] en);
    int c;
    int k;
    logic [7:0] d;
    logic [7:0] s;
    c = p % SD;
    k = (p / SD) % 8;
    if (blank || c < BC || !en[k]) return 16'hFFFF;
    d = 8'hFF ^ (8'h01 << k);
    s = seg_tab[b[4*k +: 4]];
    if (dp[k]) s[7] = 1'b0;
    return {d, s};
  endfunction

  int         p_next = 0;
  int         cur_p  = -1;
  logic [31:0] f_bcd = 32'h0;
  logic [7:0]  f_dp  = 8'h0;
  logic [7:0]  f_en  = 8'h0;
  logic [7:0]  exp_dig = 8'hFF;
  logic [7:0]  exp_seg = 8'hFF;

  always @(posedge clk) begin
    if (rst) begin
      p_next  <= 0;
      cur_p   <= -1;
      f_bcd   <= 32'h0;
      f_dp    <= 8'h0;
      f_en    <= 8'h0;
      exp_dig <= 8'hFF;
      exp_seg <= 8'hFF;
    end else begin
      cur_p  <= p_next;
      p_next <= p_next + 1;
      {exp_dig, exp_seg} <= model_out(p_next, dif.i_blank, f_bcd, f_dp, f_en);
      if (p_next % FRAME == 0) begin
        f_bcd <= dif.i_bcd;
        f_dp  <= dif.i_dp;
        f_en  <= dif.i_digit_en;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_to(input int phase);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(cur_p >= 0 && cur_p % FRAME == phase) && n < 2 * FRAME + 2);
    if (!(cur_p >= 0 && cur_p % FRAME == phase)) begin
      checks++;
      errors++;
      $display("FAIL sync_timeout: position %0d, wanted phase %0d", cur_p, phase);
    end
  endtask

  task automatic test_reset();
    logic [7:0] ed [0:5] = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFD};
    logic [7:0] es [0:5] = '{8'hFF, 8'h80, 8'h80, 8'h80, 8'hFF, 8'hF8};
    dif.i_bcd = 32'h12345678; dif.i_dp = 8'h00; dif.i_digit_en = 8'hFF; dif.i_blank = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dif.o_digits !== 8'hFF || dif.o_segments !== 8'hFF) begin
        errors++;
        $display("FAIL reset_hold: got %h/%h expected ff/ff", dif.o_digits, dif.o_segments);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (dif.o_digits !== ed[i] || dif.o_segments !== es[i]) begin
        errors++;
        $display("FAIL reset_release[%0d]: got %h/%h expected %h/%h", i,
                 dif.o_digits, dif.o_segments, ed[i], es[i]);
      end
    end
  endtask

  task automatic test_decode();
    logic [31:0] r;
    for (int v = 0; v < 16; v++) begin
      sync_to(20);
      r = $urandom();
      dif.i_bcd = {r[31:4], 4'(v)};
      sync_to(1);
      checks++;
      if (dif.o_digits !== 8'hFE || dif.o_segments !== seg_tab[v]) begin
        errors++;
        $display("FAIL decode[%0d]: got %h/%h expected fe/%h", v,
                 dif.o_digits, dif.o_segments, seg_tab[v]);
      end
    end
  endtask

  task automatic test_coherence();
    logic [7:0] d;
    sync_to(20);
    dif.i_bcd = 32'h0;
    sync_to(12);
    dif.i_bcd = 32'h99999999;
    for (int k = 3; k < 8; k++) begin
      sync_to(k * SD + 2);
      d = 8'hFF ^ (8'h01 << k);
      checks++;
      if (dif.o_digits !== d || dif.o_segments !== 8'hC0) begin
        errors++;
        $display("FAIL coherence_old[%0d]: got %h/%h expected %h/c0", k,
                 dif.o_digits, dif.o_segments, d);
      end
    end
    for (int k = 0; k < 8; k++) begin
      sync_to(k * SD + 2);
      d = 8'hFF ^ (8'h01 << k);
      checks++;
      if (dif.o_digits !== d || dif.o_segments !== 8'h90) begin
        errors++;
        $display("FAIL coherence_new[%0d]: got %h/%h expected %h/90", k,
                 dif.o_digits, dif.o_segments, d);
      end
    end
  endtask

  task automatic test_enables();
    logic [7:0] d;
    logic [7:0] s;
    sync_to(20);
    dif.i_digit_en = 8'h3F; dif.i_dp = 8'h04; dif.i_bcd = 32'h0;
    for (int k = 0; k < 8; k++) begin
      sync_to(k * SD + 2);
      if (k >= 6) begin
        d = 8'hFF; s = 8'hFF;
      end else begin
        d = 8'hFF ^ (8'h01 << k);
        s = (k == 2) ? 8'h40 : 8'hC0;
      end
      checks++;
      if (dif.o_digits !== d || dif.o_segments !== s) begin
        errors++;
        $display("FAIL enables[%0d]: got %h/%h expected %h/%h", k,
                 dif.o_digits, dif.o_segments, d, s);
      end
    end
    dif.i_digit_en = 8'hFF; dif.i_dp = 8'h00;
  endtask

  task automatic test_blank();
    logic [7:0] ed [0:4] = '{8'hFF, 8'hFF, 8'hEF, 8'hFF, 8'hDF};
    sync_to(20);
    dif.i_bcd = $urandom();
    sync_to(16);
    for (int i = 0; i < 5; i++) begin
      dif.i_blank = (i < 2);
      tick();
      checks++;
      if (dif.o_digits !== ed[i] || (i == 0 || i == 1 || i == 3) && dif.o_segments !== 8'hFF
          || dif.o_segments !== exp_seg) begin
        errors++;
        $display("FAIL blank[%0d]: got %h/%h expected %h/%h", i,
                 dif.o_digits, dif.o_segments, ed[i], exp_seg);
      end
    end
    dif.i_blank = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) dif.i_bcd = $urandom();
      if ($urandom_range(15) == 0) dif.i_dp = 8'($urandom());
      if ($urandom_range(15) == 0) dif.i_digit_en = 8'($urandom());
      dif.i_blank = ($urandom_range(9) == 0);
      tick();
      checks++;
      if (dif.o_digits !== exp_dig || dif.o_segments !== exp_seg) begin
        errors++;
        $display("FAIL random[%0d]: got %h/%h expected %h/%h", i,
                 dif.o_digits, dif.o_segments, exp_dig, exp_seg);
      end
    end
    dif.i_blank = 1'b0; dif.i_digit_en = 8'hFF; dif.i_dp = 8'h00;
  endtask

  task automatic test_midreset();
    logic [7:0] ed [0:3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFE};
    logic [7:0] es [0:3] = '{8'hFF, 8'hFF, 8'hFF, 8'hC0};
    dif.i_bcd = 32'h0;
    sync_to(5 * SD + 1);
    rst = 1'b1;
    dif.i_blank = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        rst = 1'b0;
        dif.i_blank = 1'b0;
      end
      tick();
      checks++;
      if (dif.o_digits !== ed[i] || dif.o_segments !== es[i]) begin
        errors++;
        $display("FAIL midreset[%0d]: got %h/%h expected %h/%h", i,
                 dif.o_digits, dif.o_segments, ed[i], es[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_coherence();
    test_enables();
    test_blank();
    test_random();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
